tbird_lamp_monitor: RTL and testbench

Checks the six tail-lamp drive lines produced by the turn-signal sequencer and reports what they show. It runs on the same clock as the sequencer and decodes the lamp pattern into left/right activity, completion pulses and per-side sequence counts. Any lamp pattern outside the legal sequence raises a sticky fault with a code. It sits beside the sequencer as a self-check and status source for the rest of the design.

---
 rtl/tbird_mon_pkg.sv | 27 ++
 rtl/tbird_lamp_monitor_sat_counter.sv | 25 ++
 rtl/tbird_lamp_monitor.sv | 196 +++++++++++++++++++
 tb/tb_tbird_lamp_monitor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tbird_mon_pkg.sv
// Shared definitions for the T-bird tail-lamp monitor: monitor state
// encoding and the six-bit lamp patterns {LA,LB,LC,RA,RB,RC} that make up
// the legal turn-signal sequence.
package tbird_mon_pkg;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      L1     = 4'd1,
      L2     = 4'd2,
      L3     = 4'd3,
      R1     = 4'd4,
      R2     = 4'd5,
      R3     = 4'd6,
      HAZ    = 4'd7,
      RESYNC = 4'd8
   } state_t;

   localparam logic [5:0] PAT_OFF = 6'b000_000;
   localparam logic [5:0] PAT_L1  = 6'b100_000;
   localparam logic [5:0] PAT_L2  = 6'b110_000;
   localparam logic [5:0] PAT_L3  = 6'b111_000;
   localparam logic [5:0] PAT_R1  = 6'b000_100;
   localparam logic [5:0] PAT_R2  = 6'b000_110;
   localparam logic [5:0] PAT_R3  = 6'b000_111;
   localparam logic [5:0] PAT_HAZ = 6'b111_111;

endpackage

// File: rtl/tbird_lamp_monitor_sat_counter.sv
// Saturating up-counter used for the per-side completed-sequence counts.
// Clear wins over increment; once all-ones the count holds.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   // Count completed sequences, stopping at all-ones instead of wrapping
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/tbird_lamp_monitor.sv
// Tail-lamp pattern monitor. Follows the sequencer's six lamp lines,
// reports left/right activity, completion pulses and saturating counts,
// and latches a sticky fault with the state code of the first illegal
// pattern. Hazard pattern support is enabled by defining
// TBIRD_MON_HAZARD_EN; otherwise 111111 is treated as illegal and
// HazardActive is tied low.
import tbird_mon_pkg::*;

module tbird_lamp_monitor #(
   parameter int CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Rs,
   input  logic             LA,
   input  logic             LB,
   input  logic             LC,
   input  logic             RA,
   input  logic             RB,
   input  logic             RC,
   output logic             LeftActive,
   output logic             RightActive,
   output logic             HazardActive,
   output logic             LeftDone,
   output logic             RightDone,
   output logic [CNT_W-1:0] LeftCount,
   output logic [CNT_W-1:0] RightCount,
   output logic             Fault,
   output logic [3:0]       FaultCode
);

   logic [5:0] w_pat;
   state_t     w_nextState;
   logic       w_illegal;
   logic       w_leftInc;
   logic       w_rightInc;

   state_t     r_state;
   logic       r_leftActive;
   logic       r_rightActive;
   logic       r_leftDone;
   logic       r_rightDone;
   logic       r_fault;
   logic [3:0] r_faultCode;

   assign w_pat = {LA, LB, LC, RA, RB, RC};

   // Completion is the step from the third lamp stage back to all-off;
   // the counters bump on the same edge that raises the Done pulse
   assign w_leftInc  = (r_state == L3) && (w_pat == PAT_OFF);
   assign w_rightInc = (r_state == R3) && (w_pat == PAT_OFF);

   // Decode the sampled pattern against the legal sequence; anything not
   // listed for the current state is illegal and heads to RESYNC
   always_comb begin
      w_nextState = RESYNC;
      w_illegal   = 1'b1;
      case (r_state)
         IDLE: begin
            if (w_pat == PAT_OFF) begin
               w_nextState = IDLE;
               w_illegal   = 1'b0;
            end else if (w_pat == PAT_L1) begin
               w_nextState = L1;
               w_illegal   = 1'b0;
            end else if (w_pat == PAT_R1) begin
               w_nextState = R1;
               w_illegal   = 1'b0;
`ifdef TBIRD_MON_HAZARD_EN
            end else if (w_pat == PAT_HAZ) begin
               w_nextState = HAZ;
               w_illegal   = 1'b0;
`endif
            end
         end
         L1: begin
            if (w_pat == PAT_L2) begin
               w_nextState = L2;
               w_illegal   = 1'b0;
            end
         end
         L2: begin
            if (w_pat == PAT_L3) begin
               w_nextState = L3;
               w_illegal   = 1'b0;
            end
         end
         L3: begin
            if (w_pat == PAT_OFF) begin
               w_nextState = IDLE;
               w_illegal   = 1'b0;
            end
         end
         R1: begin
            if (w_pat == PAT_R2) begin
               w_nextState = R2;
               w_illegal   = 1'b0;
            end
         end
         R2: begin
            if (w_pat == PAT_R3) begin
               w_nextState = R3;
               w_illegal   = 1'b0;
            end
         end
         R3: begin
            if (w_pat == PAT_OFF) begin
               w_nextState = IDLE;
               w_illegal   = 1'b0;
            end
         end
`ifdef TBIRD_MON_HAZARD_EN
         HAZ: begin
            if (w_pat == PAT_HAZ) begin
               w_nextState = HAZ;
               w_illegal   = 1'b0;
            end else if (w_pat == PAT_OFF) begin
               w_nextState = IDLE;
               w_illegal   = 1'b0;
            end
         end
`endif
         RESYNC: begin
            w_illegal   = 1'b0;
            w_nextState = (w_pat == PAT_OFF) ? IDLE : RESYNC;
         end
         default: begin
            w_nextState = RESYNC;
            w_illegal   = 1'b1;
         end
      endcase
   end

   // Monitor state, registered status flags and first-fault logging
   always_ff @(posedge Clk) begin
      if (Rs) begin
         r_state       <= IDLE;
         r_leftActive  <= 1'b0;
         r_rightActive <= 1'b0;
         r_leftDone    <= 1'b0;
         r_rightDone   <= 1'b0;
         r_fault       <= 1'b0;
         r_faultCode   <= 4'd0;
      end else begin
         r_state       <= w_nextState;
         r_leftActive  <= (w_nextState == L1) || (w_nextState == L2) ||
                          (w_nextState == L3);
         r_rightActive <= (w_nextState == R1) || (w_nextState == R2) ||
                          (w_nextState == R3);
         r_leftDone    <= w_leftInc;
         r_rightDone   <= w_rightInc;
         if (w_illegal && !r_fault) begin
            r_fault     <= 1'b1;
            r_faultCode <= r_state;
         end
      end
   end

`ifdef TBIRD_MON_HAZARD_EN
   logic r_hazardActive;

   // Hazard flag tracks the HAZ state one cycle behind the pattern
   always_ff @(posedge Clk) begin
      if (Rs) begin
         r_hazardActive <= 1'b0;
      end else begin
         r_hazardActive <= (w_nextState == HAZ);
      end
   end

   assign HazardActive = r_hazardActive;
`else
   assign HazardActive = 1'b0;
`endif

   sat_counter #(.CNT_W(CNT_W)) u_leftCount (
      .i_clk   (Clk),
      .i_clr   (Rs),
      .i_inc   (w_leftInc),
      .o_count (LeftCount)
   );

   sat_counter #(.CNT_W(CNT_W)) u_rightCount (
      .i_clk   (Clk),
      .i_clr   (Rs),
      .i_inc   (w_rightInc),
      .o_count (RightCount)
   );

   assign LeftActive  = r_leftActive;
   assign RightActive = r_rightActive;
   assign LeftDone    = r_leftDone;
   assign RightDone   = r_rightDone;
   assign Fault       = r_fault;
   assign FaultCode   = r_faultCode;

endmodule

// File: tb/tb_tbird_lamp_monitor.sv
// Self-checking bench for tbird_lamp_monitor (CNT_W=2 so saturation is
// reachable quickly). Expected outputs for each driven cycle are queued and
// compared one cycle later. Hazard expectations follow TBIRD_MON_HAZARD_EN.
module tb_tbird_lamp_monitor;

   localparam int CNT_W = 2;

   typedef struct {
      string       name;
      logic        rs;
      logic [5:0]  pat;
      logic [13:0] exp;
   } vec_t;

   logic             Clk;
   logic             Rs;
   logic             LA, LB, LC, RA, RB, RC;
   logic             LeftActive, RightActive, HazardActive;
   logic             LeftDone, RightDone;
   logic [CNT_W-1:0] LeftCount, RightCount;
   logic             Fault;
   logic [3:0]       FaultCode;

   int   nChecks = 0;
   int   nFails  = 0;
   vec_t tbl[$];
   vec_t expQ[$];

   tbird_lamp_monitor #(.CNT_W(CNT_W)) dut (
      .Clk          (Clk),
      .Rs           (Rs),
      .LA           (LA),
      .LB           (LB),
      .LC           (LC),
      .RA           (RA),
      .RB           (RB),
      .RC           (RC),
      .LeftActive   (LeftActive),
      .RightActive  (RightActive),
      .HazardActive (HazardActive),
      .LeftDone     (LeftDone),
      .RightDone    (RightDone),
      .LeftCount    (LeftCount),
      .RightCount   (RightCount),
      .Fault        (Fault),
      .FaultCode    (FaultCode)
   );

   // Free-running clock, period 10
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Expected output word: {la,ra,ha,ld,rd,lc[1:0],rc[1:0],f,fc[3:0]}
   function automatic vec_t mk(input string n, input logic rs, input logic [5:0] p,
                               input logic la, input logic ra, input logic ha,
                               input logic ld, input logic rd,
                               input logic [1:0] lc, input logic [1:0] rc,
                               input logic f, input logic [3:0] fc);
      vec_t v;
      v.name = n;
      v.rs   = rs;
      v.pat  = p;
      v.exp  = {la, ra, ha, ld, rd, lc, rc, f, fc};
      return v;
   endfunction

   // Drive one cycle of inputs and queue what the DUT should show next cycle
   task automatic applyStimulus(input vec_t v);
      Rs = v.rs;
      {LA, LB, LC, RA, RB, RC} = v.pat;
      expQ.push_back(v);
   endtask

   // Compare the outputs produced by the oldest queued stimulus
   task automatic checkOutput();
      vec_t        e;
      logic [13:0] act;
      if (expQ.size() > 0) begin
         e   = expQ.pop_front();
         act = {LeftActive, RightActive, HazardActive, LeftDone, RightDone,
                LeftCount, RightCount, Fault, FaultCode};
         nChecks++;
         if (act !== e.exp) begin
            nFails++;
            $display("[TB] FAIL %s: actual=%b required=%b (la ra ha ld rd lc rc f fc)",
                     e.name, act, e.exp);
         end
      end
   endtask

   // One clock step: check last cycle's result, then drive the next vector
   task automatic stepCycle(input vec_t v);
      @(negedge Clk);
      checkOutput();
      applyStimulus(v);
   endtask

   initial begin
      logic [1:0] lcPrev;
      logic [1:0] lcNew;

      Rs = 1'b1;
      {LA, LB, LC, RA, RB, RC} = 6'b000000;

      // Reset and idle
      tbl.push_back(mk("reset0", 1, 6'b000000, 0,0,0,0,0, 2'd0,2'd0, 0,4'd0));
      tbl.push_back(mk("reset1", 1, 6'b000000, 0,0,0,0,0, 2'd0,2'd0, 0,4'd0));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk("idle", 0, 6'b000000, 0,0,0,0,0, 2'd0,2'd0, 0,4'd0));

      // Left then right complete sequences
      tbl.push_back(mk("left_l1",   0, 6'b100000, 1,0,0,0,0, 2'd0,2'd0, 0,4'd0));
      tbl.push_back(mk("left_l2",   0, 6'b110000, 1,0,0,0,0, 2'd0,2'd0, 0,4'd0));
      tbl.push_back(mk("left_l3",   0, 6'b111000, 1,0,0,0,0, 2'd0,2'd0, 0,4'd0));
      tbl.push_back(mk("left_done", 0, 6'b000000, 0,0,0,1,0, 2'd1,2'd0, 0,4'd0));
      tbl.push_back(mk("right_r1",  0, 6'b000100, 0,1,0,0,0, 2'd1,2'd0, 0,4'd0));
      tbl.push_back(mk("right_r2",  0, 6'b000110, 0,1,0,0,0, 2'd1,2'd0, 0,4'd0));
      tbl.push_back(mk("right_r3",  0, 6'b000111, 0,1,0,0,0, 2'd1,2'd0, 0,4'd0));
      tbl.push_back(mk("right_done",0, 6'b000000, 0,0,0,0,1, 2'd1,2'd1, 0,4'd0));

      // Illegal from IDLE, further junk in RESYNC, recovery, then a left run
      tbl.push_back(mk("idle_fault",  0, 6'b110000, 0,0,0,0,0, 2'd1,2'd1, 1,4'd0));
      tbl.push_back(mk("resync_junk", 0, 6'b100100, 0,0,0,0,0, 2'd1,2'd1, 1,4'd0));
      tbl.push_back(mk("resync_exit", 0, 6'b000000, 0,0,0,0,0, 2'd1,2'd1, 1,4'd0));
      tbl.push_back(mk("post_l1",     0, 6'b100000, 1,0,0,0,0, 2'd1,2'd1, 1,4'd0));
      tbl.push_back(mk("post_l2",     0, 6'b110000, 1,0,0,0,0, 2'd1,2'd1, 1,4'd0));
      tbl.push_back(mk("post_l3",     0, 6'b111000, 1,0,0,0,0, 2'd1,2'd1, 1,4'd0));
      tbl.push_back(mk("post_done",   0, 6'b000000, 0,0,0,1,0, 2'd2,2'd1, 1,4'd0));

      // Reset clears fault and counts, then five left runs to saturate
      tbl.push_back(mk("reset2", 1, 6'b000000, 0,0,0,0,0, 2'd0,2'd0, 0,4'd0));
      for (int k = 0; k < 5; k++) begin
         lcPrev = (k >= 3) ? 2'd3 : 2'(k);
         lcNew  = (k >= 2) ? 2'd3 : 2'(k + 1);
         tbl.push_back(mk("sat_l1",   0, 6'b100000, 1,0,0,0,0, lcPrev,2'd0, 0,4'd0));
         tbl.push_back(mk("sat_l2",   0, 6'b110000, 1,0,0,0,0, lcPrev,2'd0, 0,4'd0));
         tbl.push_back(mk("sat_l3",   0, 6'b111000, 1,0,0,0,0, lcPrev,2'd0, 0,4'd0));
         tbl.push_back(mk("sat_done", 0, 6'b000000, 0,0,0,1,0, lcNew, 2'd0, 0,4'd0));
      end

      // Repeated L1 pattern is illegal in L1 (code 1); a later R2 fault keeps code 1
      tbl.push_back(mk("rep_l1a",   0, 6'b100000, 1,0,0,0,0, 2'd3,2'd0, 0,4'd0));
      tbl.push_back(mk("rep_l1b",   0, 6'b100000, 0,0,0,0,0, 2'd3,2'd0, 1,4'd1));
      tbl.push_back(mk("rep_exit",  0, 6'b000000, 0,0,0,0,0, 2'd3,2'd0, 1,4'd1));
      tbl.push_back(mk("r2f_r1",    0, 6'b000100, 0,1,0,0,0, 2'd3,2'd0, 1,4'd1));
      tbl.push_back(mk("r2f_r2",    0, 6'b000110, 0,1,0,0,0, 2'd3,2'd0, 1,4'd1));
      tbl.push_back(mk("r2f_bad",   0, 6'b000001, 0,0,0,0,0, 2'd3,2'd0, 1,4'd1));
      tbl.push_back(mk("r2f_exit",  0, 6'b000000, 0,0,0,0,0, 2'd3,2'd0, 1,4'd1));

      foreach (tbl[i]) stepCycle(tbl[i]);

      // Hand-written: reset while in L2 aborts without a Done or count
      stepCycle(mk("abort_rst",  1, 6'b000000, 0,0,0,0,0, 2'd0,2'd0, 0,4'd0));
      stepCycle(mk("abort_l1",   0, 6'b100000, 1,0,0,0,0, 2'd0,2'd0, 0,4'd0));
      stepCycle(mk("abort_l2",   0, 6'b110000, 1,0,0,0,0, 2'd0,2'd0, 0,4'd0));
      stepCycle(mk("abort_rs",   1, 6'b111000, 0,0,0,0,0, 2'd0,2'd0, 0,4'd0));
      stepCycle(mk("abort_idle", 0, 6'b000000, 0,0,0,0,0, 2'd0,2'd0, 0,4'd0));

      // Hand-written: repeated L3 pattern faults with code 3
      stepCycle(mk("l3f_l1",   0, 6'b100000, 1,0,0,0,0, 2'd0,2'd0, 0,4'd0));
      stepCycle(mk("l3f_l2",   0, 6'b110000, 1,0,0,0,0, 2'd0,2'd0, 0,4'd0));
      stepCycle(mk("l3f_l3",   0, 6'b111000, 1,0,0,0,0, 2'd0,2'd0, 0,4'd0));
      stepCycle(mk("l3f_bad",  0, 6'b111000, 0,0,0,0,0, 2'd0,2'd0, 1,4'd3));
      stepCycle(mk("l3f_exit", 0, 6'b000000, 0,0,0,0,0, 2'd0,2'd0, 1,4'd3));

      // Hand-written: hazard pattern held for three cycles
      stepCycle(mk("haz_rst", 1, 6'b000000, 0,0,0,0,0, 2'd0,2'd0, 0,4'd0));
`ifdef TBIRD_MON_HAZARD_EN
      stepCycle(mk("haz_1",    0, 6'b111111, 0,0,1,0,0, 2'd0,2'd0, 0,4'd0));
      stepCycle(mk("haz_2",    0, 6'b111111, 0,0,1,0,0, 2'd0,2'd0, 0,4'd0));
      stepCycle(mk("haz_3",    0, 6'b111111, 0,0,1,0,0, 2'd0,2'd0, 0,4'd0));
      stepCycle(mk("haz_off",  0, 6'b000000, 0,0,0,0,0, 2'd0,2'd0, 0,4'd0));
      stepCycle(mk("haz_4",    0, 6'b111111, 0,0,1,0,0, 2'd0,2'd0, 0,4'd0));
      stepCycle(mk("haz_bad",  0, 6'b000001, 0,0,0,0,0, 2'd0,2'd0, 1,4'd7));
      stepCycle(mk("haz_exit", 0, 6'b000000, 0,0,0,0,0, 2'd0,2'd0, 1,4'd7));
`else
      stepCycle(mk("haz_1",    0, 6'b111111, 0,0,0,0,0, 2'd0,2'd0, 1,4'd0));
      stepCycle(mk("haz_2",    0, 6'b111111, 0,0,0,0,0, 2'd0,2'd0, 1,4'd0));
      stepCycle(mk("haz_3",    0, 6'b111111, 0,0,0,0,0, 2'd0,2'd0, 1,4'd0));
      stepCycle(mk("haz_off",  0, 6'b000000, 0,0,0,0,0, 2'd0,2'd0, 1,4'd0));
      stepCycle(mk("haz_4",    0, 6'b111111, 0,0,0,0,0, 2'd0,2'd0, 1,4'd0));
      stepCycle(mk("haz_bad",  0, 6'b000001, 0,0,0,0,0, 2'd0,2'd0, 1,4'd0));
      stepCycle(mk("haz_exit", 0, 6'b000000, 0,0,0,0,0, 2'd0,2'd0, 1,4'd0));
`endif

      // Drain the last queued expectation
      @(negedge Clk);
      checkOutput();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
